// File: rtl/ram_rr_arbiter.sv
// Two-port round-robin front end for a 32x4 registered-output RAM, with a
// full-array clear sweep that locks out both ports while it runs.
module ram_rr_arbiter (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req0,
    input  logic       i_we0,
    input  logic [4:0] i_addr0,
    input  logic [3:0] i_wdata0,
    input  logic       i_req1,
    input  logic       i_we1,
    input  logic [4:0] i_addr1,
    input  logic [3:0] i_wdata1,
    input  logic       i_clr_start,
    input  logic [3:0] i_ram_q,
    output logic       o_gnt0,
    output logic       o_rvalid0,
    output logic [3:0] o_rdata0,
    output logic       o_gnt1,
    output logic       o_rvalid1,
    output logic [3:0] o_rdata1,
    output logic       o_busy,
    output logic       o_clr_done,
    output logic [4:0] o_ram_address,
    output logic [3:0] o_ram_data,
    output logic       o_ram_wren
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_cnt, w_cnt_nxt;
    logic       r_last;          // 1: port 1 was granted last, so port 0 wins a tie
    logic       r_rv0, r_rv1;
    logic [3:0] r_rd0, r_rd1;
    logic       r_clr_done;
    logic       w_gnt0, w_gnt1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        o_ram_address = 5'd0;
        o_ram_data    = 4'd0;
        o_ram_wren    = 1'b0;
        // A reset cycle performs no RAM access of any kind.
        if (!i_reset) begin
            case (r_state)
                IDLE: begin
                    if (i_clr_start) begin
                        w_state_nxt = CLEAR;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_gnt0 = i_req0 & (~i_req1 | r_last);
                        w_gnt1 = i_req1 & (~i_req0 | ~r_last);
                    end
                    if (w_gnt0) begin
                        o_ram_address = i_addr0;
                        o_ram_data    = i_wdata0;
                        o_ram_wren    = i_we0;
                    end else if (w_gnt1) begin
                        o_ram_address = i_addr1;
                        o_ram_data    = i_wdata1;
                        o_ram_wren    = i_we1;
                    end
                end
                CLEAR: begin
                    o_ram_address = r_cnt;
                    o_ram_wren    = 1'b1;
                    w_cnt_nxt     = r_cnt + 5'd1;
                    if (r_cnt == 5'd31) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= 5'd0;
            r_last     <= 1'b1;
            r_rv0      <= 1'b0;
            r_rv1      <= 1'b0;
            r_rd0      <= 4'd0;
            r_rd1      <= 4'd0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_gnt0)      r_last <= 1'b0;
            else if (w_gnt1) r_last <= 1'b1;
            r_rv0      <= w_gnt0 & ~i_we0;
            r_rv1      <= w_gnt1 & ~i_we1;
            if (r_rv0) r_rd0 <= i_ram_q;
            if (r_rv1) r_rd1 <= i_ram_q;
            r_clr_done <= (r_state == CLEAR) && (r_cnt == 5'd31);
        end
    end

    // RAM output is already registered, so read data is passed straight through
    // on the rvalid cycle and captured to hold it afterwards.
    assign o_rdata0   = r_rv0 ? i_ram_q : r_rd0;
    assign o_rdata1   = r_rv1 ? i_ram_q : r_rd1;
    assign o_rvalid0  = r_rv0;
    assign o_rvalid1  = r_rv1;
    assign o_gnt0     = w_gnt0;
    assign o_gnt1     = w_gnt1;
    assign o_busy     = (r_state == CLEAR);
    assign o_clr_done = r_clr_done;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Randomized + directed bench for ram_rr_arbiter: cycle-level reference model
// of the arbitration/clear rules plus a read-data scoreboard per port.
module tb_ram_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0, clr_start = 0;
    logic [4:0] addr0 = 0, addr1 = 0;
    logic [3:0] wdata0 = 0, wdata1 = 0;
    logic [3:0] ram_q;
    logic       gnt0, rvalid0, gnt1, rvalid1, busy, clr_done, ram_wren;
    logic [3:0] rdata0, rdata1, ram_data;
    logic [4:0] ram_address;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter dut (
        .i_clock(clk), .i_reset(rst),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .i_clr_start(clr_start), .i_ram_q(ram_q),
        .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
        .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
        .o_busy(busy), .o_clr_done(clr_done),
        .o_ram_address(ram_address), .o_ram_data(ram_data), .o_ram_wren(ram_wren)
    );

    // 32x4 RAM with registered output, old data on read-during-write
    logic [3:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_clearing = 0;
    int         m_idx = 0;
    int         m_last = 1;
    bit         m_done = 0;
    bit         m_rv0 = 0, m_rv1 = 0;
    logic [3:0] m_mem [32];
    logic [3:0] q0[$], q1[$];
    logic [3:0] hold0 = 0, hold1 = 0;

    initial forever begin
        int         pick;
        logic       e_wren;
        logic [4:0] e_addr;
        logic [3:0] e_data;
        logic       pwe;
        logic [4:0] pa;
        logic [3:0] pd;
        @(negedge clk);
        #1;
        pick = -1; e_wren = 0; e_addr = 0; e_data = 0;
        pwe = 0; pa = 0; pd = 0;
        if (!rst) begin
            if (m_clearing) begin
                e_wren = 1; e_addr = 5'(m_idx);
            end else if (!clr_start) begin
                if (req0 && req1) pick = (m_last == 1) ? 0 : 1;
                else if (req0) pick = 0;
                else if (req1) pick = 1;
            end
        end
        if (pick >= 0) begin
            pwe = (pick == 0) ? we0 : we1;
            pa  = (pick == 0) ? addr0 : addr1;
            pd  = (pick == 0) ? wdata0 : wdata1;
            e_wren = pwe; e_addr = pa; e_data = pd;
        end
        chk("gnt0", gnt0, pick == 0);
        chk("gnt1", gnt1, pick == 1);
        chk("ram_wren", ram_wren, e_wren);
        chk("ram_address", ram_address, e_addr);
        chk("ram_data", ram_data, e_data);
        chk("busy", busy, m_clearing);
        chk("clr_done", clr_done, m_done);
        chk("rvalid0", rvalid0, m_rv0);
        chk("rvalid1", rvalid1, m_rv1);
        if (rst) begin
            m_clearing = 0; m_idx = 0; m_last = 1; m_done = 0;
            m_rv0 = 0; m_rv1 = 0;
            q0.delete(); q1.delete();
            hold0 = 0; hold1 = 0;
        end else begin
            m_done = m_clearing && (m_idx == 31);
            m_rv0 = 0; m_rv1 = 0;
            if (m_clearing) begin
                m_mem[m_idx] = 4'h0;
                m_idx++;
                if (m_idx == 32) begin
                    m_clearing = 0; m_idx = 0;
                end
            end else if (clr_start) begin
                m_clearing = 1;
            end else if (pick >= 0) begin
                m_last = pick;
                if (pwe) m_mem[pa] = pd;
                else if (pick == 0) begin m_rv0 = 1; q0.push_back(m_mem[pa]); end
                else begin m_rv1 = 1; q1.push_back(m_mem[pa]); end
            end
        end
    end

    // ---------------- read-data monitor ----------------
    initial forever begin
        logic [3:0] e;
        @(negedge clk);
        if (rvalid0) begin
            if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
            else begin e = q0.pop_front(); chk("rdata0", rdata0, e); hold0 = e; end
        end else chk("rdata0_hold", rdata0, hold0);
        if (rvalid1) begin
            if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
            else begin e = q1.pop_front(); chk("rdata1", rdata1, e); hold1 = e; end
        end else chk("rdata1_hold", rdata1, hold1);
    end

    // ---------------- stimulus ----------------
    logic g0 = 0, g1 = 0;

    task automatic step();
        @(negedge clk);
        g0 = gnt0; g1 = gnt1;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [4:0] a, input logic [3:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [4:0] a, input logic [3:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = 4'($urandom);
            m_mem[i] = ram_mem[i];
        end
        repeat (3) step();
        rst = 0;

        // write 0xA to addr 5, then read it back on port 0
        set0(1, 1, 5, 4'hA); step();
        set0(1, 0, 5, 0);    step();
        set0(0, 0, 0, 0);    repeat (2) step();

        // both ports reading for 4 cycles: alternating grants
        set0(1, 0, 1, 0); set1(1, 0, 2, 0);
        repeat (4) step();
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); step();

        // fill with 0xF, clear, read everything back
        for (int a = 0; a < 32; a++) begin set0(1, 1, 5'(a), 4'hF); step(); end
        set0(0, 0, 0, 0);
        clr_start = 1; step(); clr_start = 0;
        repeat (33) step();
        for (int a = 0; a < 32; a++) begin set1(1, 0, 5'(a), 0); step(); end
        set1(0, 0, 0, 0); step();

        // clr_start together with req1: req1 waits for the sweep
        clr_start = 1; set1(1, 0, 7, 0); step(); clr_start = 0;
        for (int k = 0; k < 40 && !g1; k++) step();
        chk("req1_after_clear_granted", g1, 1);
        set1(0, 0, 0, 0); step();

        // reset in the middle of a sweep; addr 20 must keep 0x5
        set0(1, 1, 20, 4'h5); step(); set0(0, 0, 0, 0);
        clr_start = 1; step(); clr_start = 0;
        repeat (10) step();
        rst = 1; step(); rst = 0;
        set0(1, 0, 20, 0); step(); set0(0, 0, 0, 0); repeat (2) step();

        // port0 writes addr 3 while port1 reads it
        set0(1, 1, 3, 4'h9); set1(1, 0, 3, 0);
        for (int k = 0; k < 4 && !(g0 && g1); k++) begin
            step();
            if (g0) set0(0, 0, 0, 0);
            if (g1) set1(0, 0, 0, 0);
        end
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); repeat (2) step();

        // randomized traffic, requests held until granted
        for (int i = 0; i < 3000; i++) begin
            if (!req0 || g0) begin
                if ($urandom_range(0, 1) == 1) set0(1, 1'($urandom), 5'($urandom), 4'($urandom));
                else set0(0, 0, 0, 0);
            end
            if (!req1 || g1) begin
                if ($urandom_range(0, 1) == 1) set1(1, 1'($urandom), 5'($urandom), 4'($urandom));
                else set1(0, 0, 0, 0);
            end
            clr_start = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); clr_start = 0; rst = 0;
        repeat (40) step();
        chk("pending_reads_drained", 32'(q0.size() + q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
